// File: rtl/uart_tx_fifo_param.sv
// Purpose : buffered UART transmitter; words queue in a sync FIFO, sent LSB-first.
// Latency : write into an empty FIFO at t -> EMPTY low t+1, pop t+1, start bit on UART_TXD at t+2.
// Backpr. : no ready handshake; FULL advertises capacity and a write while FULL is dropped.
//
// Ports (uart_tx_fifo_param):
//   CLK, RST_N       clock, asynchronous active-low reset (abandons frame, flushes FIFO)
//   WR_EN, WR_DATA   push a DATA_BITS word into the FIFO
//   FULL, EMPTY      FIFO status; LEVEL is occupancy (FIFO_AW+1 bits)
//   BUSY             high while a frame is on the line
//   DONE             one-cycle pulse after the last stop bit of every frame
//   UART_TXD         serial line, idles high
// Optional feature: define UART_TX_CTS_EN to add CTS_N (active-low clear-to-send,
// 2-flop synchronised). It gates the start of every frame, never a frame in flight.

// Purpose : generic synchronous FIFO, first-word-fall-through head.
// Latency : a push is visible on head_dat and in level one cycle later.
// Backpr. : push while full and pop while empty are ignored.
module uart_tx_sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push  = push_vld & ~full;
  assign do_pop   = pop & ~empty;
  // Pointers carry one extra wrap bit so their difference is the occupancy.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == DEPTH);
  assign empty    = (level == '0);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module uart_tx_fifo_param #(
  parameter int DIV         = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_AW     = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
`ifdef UART_TX_CTS_EN
  input  logic                 CTS_N,
`endif
  input  logic                 WR_EN,
  input  logic [DATA_BITS-1:0] WR_DATA,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic [FIFO_AW:0]     LEVEL,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 UART_TXD
);
  generate
    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_AW < 1) begin : g_bad_param
      $error("uart_tx_fifo_param: illegal parameter combination");
    end
  endgenerate

  localparam int          CW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic        ODD       = (PARITY_MODE == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   done_q, done_d;
  logic                   fifo_pop;
  logic [DATA_BITS-1:0]   head_dat;
  logic                   cts_ok;
  logic                   tick;

  uart_tx_sync_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .push_vld (WR_EN),
    .push_dat (WR_DATA),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (FULL),
    .empty    (EMPTY),
    .level    (LEVEL)
  );

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;
  // Resets to "not clear" so nothing launches until the peer is seen ready.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cts_sync_q <= 2'b11;
    else        cts_sync_q <= {cts_sync_q[0], CTS_N};
  end
  assign cts_ok = ~cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    txd_d    = 1'b1;

    if (state_q != S_IDLE) begin
      if (!tick) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        cnt_d = DIV_M1;
        case (state_q)
          S_START: begin
            state_d = S_DATA;
            bit_d   = '0;
          end
          S_DATA: begin
            shift_d = shift_q >> 1;
            if (bit_q == LAST_DATA) begin
              state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
          S_PARITY: begin
            state_d = S_STOP;
            bit_d   = '0;
          end
          S_STOP: begin
            if (bit_q == LAST_STOP) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // One launch path serves both IDLE and the end of the final stop bit,
    // which is what makes back-to-back frames gapless.
    if (state_d == S_IDLE && !EMPTY && cts_ok) begin
      fifo_pop = 1'b1;
      shift_d  = head_dat;
      par_d    = (^head_dat) ^ ODD;
      cnt_d    = DIV_M1;
      bit_d    = '0;
      state_d  = S_START;
    end

    // Line level is registered from the next state so UART_TXD is glitch-free.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = done_q;
  assign UART_TXD = txd_q;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo_param;
  localparam int DIV = 4;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         fall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: 8N1, 4-deep FIFO
  logic       wr_en_a;
  logic [7:0] wr_dat_a;
  logic       full_a, empty_a, busy_a, done_a, txd_a;
  logic [2:0] level_a;
  // DUT B (7E2) and DUT C (7O2)
  logic       wr_en_b, wr_en_c;
  logic [6:0] wr_dat_p;
  logic       full_b, empty_b, busy_b, done_b, txd_b;
  logic       full_c, empty_c, busy_c, done_c, txd_c;
  logic [2:0] level_b, level_c;
  logic       psel;
  logic       txd_p, done_p, busy_p;
  assign txd_p  = psel ? txd_c  : txd_b;
  assign done_p = psel ? done_c : done_b;
  assign busy_p = psel ? busy_c : busy_b;

  uart_tx_fifo_param #(.DIV(DIV), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_AW(2)) u_dut_a (
    .CLK(clk), .RST_N(rst_n),
`ifdef UART_TX_CTS_EN
    .CTS_N(1'b0),
`endif
    .WR_EN(wr_en_a), .WR_DATA(wr_dat_a), .FULL(full_a), .EMPTY(empty_a),
    .LEVEL(level_a), .BUSY(busy_a), .DONE(done_a), .UART_TXD(txd_a));

  uart_tx_fifo_param #(.DIV(DIV), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_AW(2)) u_dut_b (
    .CLK(clk), .RST_N(rst_n),
`ifdef UART_TX_CTS_EN
    .CTS_N(1'b0),
`endif
    .WR_EN(wr_en_b), .WR_DATA(wr_dat_p), .FULL(full_b), .EMPTY(empty_b),
    .LEVEL(level_b), .BUSY(busy_b), .DONE(done_b), .UART_TXD(txd_b));

  uart_tx_fifo_param #(.DIV(DIV), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_AW(2)) u_dut_c (
    .CLK(clk), .RST_N(rst_n),
`ifdef UART_TX_CTS_EN
    .CTS_N(1'b0),
`endif
    .WR_EN(wr_en_c), .WR_DATA(wr_dat_p), .FULL(full_c), .EMPTY(empty_c),
    .LEVEL(level_c), .BUSY(busy_c), .DONE(done_c), .UART_TXD(txd_c));

  int   checks = 0;
  int   failures = 0;
  int   frames_a = 0;
  exp_t qa[$];
  exp_t qp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic p, input int f);
    exp_t e;
    e.data = d;
    e.par  = p;
    e.fall = f;
    return e;
  endfunction

  // Decode one captured frame (DIV samples per bit) as a receiver would.
  task automatic check_frame(input string tag, input logic [63:0] s, input int dbits,
                             input bit haspar, input int nstop, input int fall, input exp_t e);
    int nb;
    int bad;
    logic [7:0] d;
    nb  = 1 + dbits + (haspar ? 1 : 0) + nstop;
    bad = 0;
    for (int k = 0; k < nb; k++)
      for (int j = 1; j < DIV; j++)
        if (s[DIV*k+j] !== s[DIV*k]) bad++;
    chk({tag, "_bit_width"}, bad, 0);
    d = '0;
    for (int j = 0; j < dbits; j++) d[j] = s[DIV*(1+j)];
    chk({tag, "_data"}, d, e.data);
    if (haspar) chk({tag, "_parity"}, s[DIV*(1+dbits)], e.par);
    bad = 0;
    for (int k = nb - nstop; k < nb; k++)
      if (s[DIV*k] !== 1'b1) bad++;
    chk({tag, "_stop"}, bad, 0);
    chk({tag, "_fall_cycle"}, fall, e.fall);
  endtask

  // Monitor for DUT A (40-clock frames)
  initial begin : mon_a
    logic [63:0] s;
    int fall, bad_done;
    bit pending, aborted;
    exp_t e;
    pending = 0;
    forever begin
      if (!pending) begin
        @(negedge clk);
        if (rst_n && done_a) chk("a_done_stray", done_a, 0);
      end
      pending = 0;
      if (rst_n && txd_a === 1'b0) begin
        fall = cyc; s = '0; aborted = 0; bad_done = 0;
        for (int j = 0; j < 10*DIV; j++) begin
          if (j > 0) @(negedge clk);
          if (!rst_n) begin aborted = 1; break; end
          s[j] = txd_a;
          if (j > 0 && done_a) bad_done++;
        end
        if (!aborted) begin
          frames_a++;
          chk("a_frame_expected", qa.size() != 0, 1);
          if (qa.size() != 0) begin
            e = qa.pop_front();
            check_frame("a", s, 8, 0, 1, fall, e);
          end
          @(negedge clk);
          if (rst_n) begin
            chk("a_done_early", bad_done, 0);
            chk("a_done_pulse", done_a, 1);
            pending = (txd_a === 1'b0);
          end
        end
      end
    end
  end

  // Monitor for the selected parity DUT (44-clock frames)
  initial begin : mon_p
    logic [63:0] s;
    int fall, bad_done;
    bit pending, aborted;
    exp_t e;
    pending = 0;
    forever begin
      if (!pending) begin
        @(negedge clk);
        if (rst_n && done_p) chk("p_done_stray", done_p, 0);
      end
      pending = 0;
      if (rst_n && txd_p === 1'b0) begin
        fall = cyc; s = '0; aborted = 0; bad_done = 0;
        for (int j = 0; j < 11*DIV; j++) begin
          if (j > 0) @(negedge clk);
          if (!rst_n) begin aborted = 1; break; end
          s[j] = txd_p;
          if (j > 0 && done_p) bad_done++;
        end
        if (!aborted) begin
          chk("p_frame_expected", qp.size() != 0, 1);
          if (qp.size() != 0) begin
            e = qp.pop_front();
            check_frame("p", s, 7, 1, 2, fall, e);
          end
          @(negedge clk);
          if (rst_n) begin
            chk("p_done_early", bad_done, 0);
            chk("p_done_pulse", done_p, 1);
            pending = (txd_p === 1'b0);
          end
        end
      end
    end
  end

  task automatic drain(input string tag, input bit which_p);
    int n;
    n = 0;
    while ((which_p ? (qp.size() != 0 || busy_p) : (qa.size() != 0 || busy_a)) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_in_time"}, n < 1000, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c, f0;
    int rb[6];
    logic [7:0] b2b[3];
    logic [7:0] ov[6];
    b2b = '{8'h55, 8'h0F, 8'hF0};
    ov  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    wr_en_a = 0; wr_dat_a = '0; wr_en_b = 0; wr_en_c = 0; wr_dat_p = '0; psel = 0;

    // Reset
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk("rst_txd_during", txd_a, 1);
    #47 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) rb[i] = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd_a !== 1'b1)    rb[0]++;
      if (empty_a !== 1'b1)  rb[1]++;
      if (level_a !== 3'd0)  rb[2]++;
      if (busy_a !== 1'b0)   rb[3]++;
      if (full_a !== 1'b0)   rb[4]++;
      if (done_a !== 1'b0)   rb[5]++;
    end
    chk("rst_txd_high", rb[0], 0);
    chk("rst_empty",    rb[1], 0);
    chk("rst_level",    rb[2], 0);
    chk("rst_busy",     rb[3], 0);
    chk("rst_full",     rb[4], 0);
    chk("rst_done",     rb[5], 0);

    // Single 8N1 frame: 8'hA5
    @(negedge clk); c = cyc;
    wr_en_a = 1; wr_dat_a = 8'hA5; qa.push_back(mk(8'hA5, 1'b0, c + 2));
    @(negedge clk); wr_en_a = 0;
    chk("lat_empty_t1", empty_a, 0);
    chk("lat_level_t1", level_a, 1);
    @(negedge clk);
    chk("lat_busy_t2",  busy_a, 1);
    chk("lat_empty_t2", empty_a, 1);
    drain("single", 0);

    // Back-to-back: three contiguous 40-clock frames
    @(negedge clk); c = cyc;
    for (int i = 0; i < 3; i++) begin
      wr_en_a = 1; wr_dat_a = b2b[i];
      qa.push_back(mk(b2b[i], 1'b0, c + 2 + 40*i));
      @(negedge clk);
    end
    wr_en_a = 0;
    while (cyc < c + 81) @(negedge clk);
    chk("b2b_empty_before_pop3", empty_a, 0);
    chk("b2b_level_before_pop3", level_a, 1);
    @(negedge clk);
    chk("b2b_empty_after_pop3", empty_a, 1);
    chk("b2b_level_after_pop3", level_a, 0);
    drain("b2b", 0);

    // Overflow: 6 writes into a 4-deep FIFO behind one frame in flight
    f0 = frames_a;
    @(negedge clk); c = cyc;
    for (int i = 0; i < 6; i++) begin
      wr_en_a = 1; wr_dat_a = ov[i];
      if (i < 5) qa.push_back(mk(ov[i], 1'b0, c + 2 + 40*i));
      if (i == 5) begin
        chk("ovf_full",  full_a, 1);
        chk("ovf_level", level_a, 4);
      end
      @(negedge clk);
    end
    wr_en_a = 0;
    chk("ovf_drop_level", level_a, 4);
    chk("ovf_drop_full",  full_a, 1);
    drain("ovf", 0);
    chk("ovf_frame_count", frames_a - f0, 5);

    // 7E2: 7'h03 -> parity 0, 7'h07 -> parity 1, 44-clock frames back-to-back
    psel = 0;
    @(negedge clk); c = cyc;
    wr_en_b = 1; wr_dat_p = 7'h03; qp.push_back(mk(8'h03, 1'b0, c + 2));
    @(negedge clk);
    wr_dat_p = 7'h07; qp.push_back(mk(8'h07, 1'b1, c + 2 + 44));
    @(negedge clk); wr_en_b = 0;
    drain("par_even", 1);

    // 7O2: 7'h03 -> parity 1
    psel = 1;
    @(negedge clk); c = cyc;
    wr_en_c = 1; wr_dat_p = 7'h03; qp.push_back(mk(8'h03, 1'b1, c + 2));
    @(negedge clk); wr_en_c = 0;
    drain("par_odd", 1);
    psel = 0;

    // Mid-frame reset during DATA of a 3-word burst
    @(negedge clk); c = cyc;
    wr_en_a = 1; wr_dat_a = 8'h00; @(negedge clk);
    wr_dat_a = 8'h3C; @(negedge clk);
    wr_dat_a = 8'hC3; @(negedge clk);
    wr_en_a = 0;
    while (cyc < c + 10) @(negedge clk);
    chk("mid_pre_txd",   txd_a, 0);
    chk("mid_pre_busy",  busy_a, 1);
    chk("mid_pre_level", level_a, 2);
    f0 = frames_a;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_txd",   txd_a, 1);
    chk("mid_rst_level", level_a, 0);
    chk("mid_rst_busy",  busy_a, 0);
    chk("mid_rst_empty", empty_a, 1);
    chk("mid_rst_done",  done_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) rb[i] = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd_a !== 1'b1)   rb[0]++;
      if (busy_a !== 1'b0)  rb[1]++;
      if (level_a !== 3'd0) rb[2]++;
    end
    chk("mid_post_txd_idle", rb[0], 0);
    chk("mid_post_busy",     rb[1], 0);
    chk("mid_post_level",    rb[2], 0);
    chk("mid_post_frames",   frames_a - f0, 0);

    chk("sb_a_drained", qa.size(), 0);
    chk("sb_p_drained", qp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
